fc_flatten_buffer: RTL and testbench

//  Collects the channel-parallel pixel stream from the last pooling stage and

---
 rtl/fc_flatten_buffer_pkg.sv | 14 +
 rtl/fc_flatten_buffer.sv | 96 +++++++++
 tb/tb_fc_flatten_buffer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fc_flatten_buffer_pkg.sv
// Shared sizing for the FC flatten stage: element count, element width and
// channel count of the last pooling stage, plus the fill-state encoding.
package fc_flatten_buffer_pkg;

    localparam int FC_IN_VEC = 48;
    localparam int OF_BW     = 8;
    localparam int FC_CH     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/fc_flatten_buffer.sv
// Flattens one frame of the channel-parallel pooling stream into a packed
// channel-major vector (idx = ch*BEATS + beat) for the FC stage.
module fc_flatten_buffer
    import fc_flatten_buffer_pkg::*;
#(
    parameter int CH  = FC_CH,
    parameter int VEC = FC_IN_VEC,
    parameter int BW  = OF_BW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_in_valid,
    input  logic              i_frame_start,
    input  logic [CH*BW-1:0]  i_in_pix,
    output logic              o_ot_valid,
    output logic [VEC*BW-1:0] o_ot_fmap,
    output logic              o_busy,
    output logic              o_frame_drop
);

    localparam int BEATS  = VEC / CH;
    localparam int CNT_BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    fill_state_e       state_q, state_d;
    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic [CNT_BW-1:0] wr_beat;
    logic              last_beat;
    logic              drop_d;

    logic [VEC*BW-1:0] fill_q;
    logic [VEC*BW-1:0] fill_nxt;
    logic [VEC*BW-1:0] fmap_q;
    logic              valid_q;
    logic              drop_q;

    // A qualified frame_start always restarts at beat 0, discarding any partial frame.
    always_comb begin
        wr_beat   = i_frame_start ? '0 : cnt_q;
        last_beat = i_in_valid && (wr_beat == CNT_BW'(BEATS - 1));
        drop_d    = i_in_valid && i_frame_start && (state_q == ST_FILL);
        cnt_d     = cnt_q;
        if (i_in_valid) begin
            cnt_d = last_beat ? '0 : wr_beat + 1'b1;
        end
        state_d = (cnt_d != '0) ? ST_FILL : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // fill_nxt already carries the current beat, so the snapshot on the last
    // beat needs no extra cycle.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar b = 0; b < BEATS; b++) begin : g_beat
            localparam int K = c * BEATS + b;
            logic we;
            assign we = i_in_valid && (wr_beat == CNT_BW'(b));
            assign fill_nxt[K*BW +: BW] = we ? i_in_pix[c*BW +: BW] : fill_q[K*BW +: BW];

            always_ff @(posedge clk) begin
                if (reset) begin
                    fill_q[K*BW +: BW] <= '0;
                end else begin
                    fill_q[K*BW +: BW] <= fill_nxt[K*BW +: BW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fmap_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            if (last_beat) begin
                fmap_q <= fill_nxt;
            end
            valid_q <= last_beat;
            drop_q  <= drop_d;
        end
    end

    assign o_ot_valid   = valid_q;
    assign o_ot_fmap    = fmap_q;
    assign o_busy       = (state_q == ST_FILL);
    assign o_frame_drop = drop_q;

endmodule

// File: tb/tb_fc_flatten_buffer.sv
// Bench for fc_flatten_buffer: directed scenarios plus a random stream,
// checked against a beat-queue model of one frame.
module tb_fc_flatten_buffer;

    localparam int CH    = 3;
    localparam int VEC   = 48;
    localparam int BW    = 8;
    localparam int BEATS = VEC / CH;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_in_valid;
    logic              i_frame_start;
    logic [CH*BW-1:0]  i_in_pix;
    logic              o_ot_valid;
    logic [VEC*BW-1:0] o_ot_fmap;
    logic              o_busy;
    logic              o_frame_drop;

    fc_flatten_buffer #(.CH(CH), .VEC(VEC), .BW(BW)) dut (
        .clk(clk), .reset(reset), .i_in_valid(i_in_valid), .i_frame_start(i_frame_start),
        .i_in_pix(i_in_pix), .o_ot_valid(o_ot_valid), .o_ot_fmap(o_ot_fmap),
        .o_busy(o_busy), .o_frame_drop(o_frame_drop)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: the beats of the frame in progress, and the expected outputs.
    logic [CH*BW-1:0]  m_q[$];
    logic [VEC*BW-1:0] m_fmap;
    logic              m_valid, m_drop, m_busy;

    task automatic tick(input logic v, input logic fs, input logic [CH*BW-1:0] pix);
        i_in_valid = v; i_frame_start = fs; i_in_pix = pix;
        @(posedge clk); #1;
        m_valid = 1'b0; m_drop = 1'b0;
        if (reset) begin
            m_q.delete(); m_fmap = '0;
        end else if (v) begin
            if (fs && m_q.size() != 0) begin m_drop = 1'b1; m_q.delete(); end
            m_q.push_back(pix);
            if (m_q.size() == BEATS) begin
                for (int b = 0; b < BEATS; b++)
                    for (int c = 0; c < CH; c++)
                        m_fmap[(c*BEATS+b)*BW +: BW] = m_q[b][c*BW +: BW];
                m_valid = 1'b1;
                m_q.delete();
            end
        end
        m_busy = (m_q.size() != 0);
    endtask

    function automatic logic [CH*BW-1:0] rand_pix();
        logic [CH*BW-1:0] p;
        for (int c = 0; c < CH; c++) begin
            case ($urandom_range(0, 3))
                0: p[c*BW +: BW] = 8'h80;
                1: p[c*BW +: BW] = 8'h7f;
                default: p[c*BW +: BW] = 8'($urandom);
            endcase
        end
        return p;
    endfunction

    function automatic logic [CH*BW-1:0] ord_pix(input int b, input int sign);
        logic [CH*BW-1:0] p;
        for (int c = 0; c < CH; c++) p[c*BW +: BW] = 8'(sign * (c*BEATS + b));
        return p;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        reset = 1'b0;
        for (int b = 0; b < 7; b++) tick(1'b1, b == 0, rand_pix());
        n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL reset_prebusy: got %b want 1", o_busy); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, rand_pix());
            n_chk++;
            if ({o_ot_valid, o_busy, o_frame_drop} !== 3'b000 || o_ot_fmap !== '0) begin
                n_fail++; $display("FAIL reset_outputs: got v=%b busy=%b drop=%b fmap=%h want all 0",
                                   o_ot_valid, o_busy, o_frame_drop, o_ot_fmap);
            end
        end
        reset = 1'b0;
        tick(1'b0, 1'b0, '0);
        n_chk++; if (o_frame_drop !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_after: got drop=%b busy=%b want 0 0", o_frame_drop, o_busy); end
        for (int b = 0; b < BEATS; b++) begin
            tick(1'b1, b == 0, rand_pix());
            n_chk++; if (o_ot_valid !== m_valid || o_busy !== m_busy) begin n_fail++; $display("FAIL reset_fresh_ctl: got v=%b busy=%b want %b %b", o_ot_valid, o_busy, m_valid, m_busy); end
        end
        n_chk++; if (o_ot_fmap !== m_fmap) begin n_fail++; $display("FAIL reset_fresh_fmap: got %h want %h", o_ot_fmap, m_fmap); end
    endtask

    task automatic test_ordering();
        for (int b = 0; b < BEATS; b++) begin
            tick(1'b1, b == 0, ord_pix(b, 1));
            n_chk++; if (o_ot_valid !== (b == BEATS-1)) begin n_fail++; $display("FAIL order_valid: beat %0d got %b", b, o_ot_valid); end
        end
        for (int k = 0; k < VEC; k++) begin
            n_chk++; if (o_ot_fmap[k*BW +: BW] !== 8'(k)) begin n_fail++; $display("FAIL order_elem: k=%0d got %0d want %0d", k, o_ot_fmap[k*BW +: BW], k); end
        end
        tick(1'b0, 1'b0, '0);
        n_chk++; if (o_ot_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL order_after: got v=%b busy=%b want 0 0", o_ot_valid, o_busy); end
    endtask

    task automatic test_gaps();
        logic [VEC*BW-1:0] prev;
        prev = o_ot_fmap;
        for (int b = 0; b < BEATS; b++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 1'b0, rand_pix());
                n_chk++; if (o_ot_valid !== 1'b0 || o_ot_fmap !== prev || o_busy !== (b != 0)) begin
                    n_fail++; $display("FAIL gap_idle: beat %0d got v=%b busy=%b", b, o_ot_valid, o_busy); end
            end
            tick(1'b1, b == 0, ord_pix(b, 1));
            n_chk++; if (o_ot_valid !== (b == BEATS-1)) begin n_fail++; $display("FAIL gap_valid: beat %0d got %b", b, o_ot_valid); end
        end
        for (int k = 0; k < VEC; k++) begin
            n_chk++; if (o_ot_fmap[k*BW +: BW] !== 8'(k)) begin n_fail++; $display("FAIL gap_elem: k=%0d got %0d want %0d", k, o_ot_fmap[k*BW +: BW], k); end
        end
    endtask

    task automatic test_back_to_back();
        int t = 0, p1 = -1, p2 = -1;
        logic [VEC*BW-1:0] f1;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < BEATS; b++) begin
                tick(1'b1, b == 0, ord_pix(b, f == 0 ? 1 : -1));
                t++;
                if (o_ot_valid) begin if (p1 < 0) p1 = t; else p2 = t; end
                if (f == 1 && b < BEATS-1) begin
                    n_chk++; if (o_ot_fmap !== f1) begin n_fail++; $display("FAIL b2b_hold: beat %0d got %h want %h", b, o_ot_fmap, f1); end
                end
            end
            if (f == 0) f1 = o_ot_fmap;
        end
        n_chk++; if (p2 - p1 !== 16) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 16", p2 - p1); end
        for (int k = 0; k < VEC; k++) begin
            n_chk++; if (f1[k*BW +: BW] !== 8'(k) || o_ot_fmap[k*BW +: BW] !== 8'(-k)) begin
                n_fail++; $display("FAIL b2b_elem: k=%0d got %0d/%0d want %0d/%0d", k, f1[k*BW +: BW], o_ot_fmap[k*BW +: BW], 8'(k), 8'(-k)); end
        end
    endtask

    task automatic test_resync();
        for (int b = 0; b < 5; b++) tick(1'b1, b == 0, ord_pix(b, 1));
        tick(1'b1, 1'b1, rand_pix());
        n_chk++; if (o_frame_drop !== 1'b1 || o_busy !== 1'b1) begin n_fail++; $display("FAIL resync_drop: got drop=%b busy=%b want 1 1", o_frame_drop, o_busy); end
        for (int b = 1; b < BEATS; b++) begin
            tick(1'b1, 1'b0, rand_pix());
            n_chk++; if (o_frame_drop !== 1'b0 || o_ot_valid !== m_valid) begin n_fail++; $display("FAIL resync_ctl: beat %0d got drop=%b v=%b want 0 %b", b, o_frame_drop, o_ot_valid, m_valid); end
        end
        n_chk++; if (o_ot_fmap !== m_fmap) begin n_fail++; $display("FAIL resync_fmap: got %h want %h", o_ot_fmap, m_fmap); end
    endtask

    task automatic test_stray();
        for (int b = 0; b < 3; b++) tick(1'b1, b == 0, rand_pix());
        tick(1'b0, 1'b1, rand_pix());
        n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL stray_busy: got %b want 1", o_busy); end
        tick(1'b0, 1'b0, '0);
        n_chk++; if (o_frame_drop !== 1'b0) begin n_fail++; $display("FAIL stray_drop: got %b want 0", o_frame_drop); end
        for (int b = 3; b < BEATS; b++) tick(1'b1, 1'b0, rand_pix());
        n_chk++; if (o_ot_valid !== 1'b1 || o_ot_fmap !== m_fmap) begin n_fail++; $display("FAIL stray_frame: got v=%b fmap=%h want 1 %h", o_ot_valid, o_ot_fmap, m_fmap); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rand_pix());
            n_chk++;
            if (o_ot_valid !== m_valid || o_frame_drop !== m_drop || o_busy !== m_busy || o_ot_fmap !== m_fmap) begin
                n_fail++; $display("FAIL random: cyc %0d got v=%b drop=%b busy=%b want %b %b %b fmap_ok=%b",
                                   i, o_ot_valid, o_frame_drop, o_busy, m_valid, m_drop, m_busy, o_ot_fmap === m_fmap);
            end
        end
    endtask

    initial begin
        reset = 1'b1; i_in_valid = 1'b0; i_frame_start = 1'b0; i_in_pix = '0;
        test_reset();
        test_ordering();
        test_gaps();
        test_back_to_back();
        test_resync();
        test_stray();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
